// File: rtl/encoder32x5_rr.sv
// Registered 32-to-5 arbitrating encoder with a valid/ready output stage.
// Define RR_FAIRNESS_EN for a round-robin pointer; otherwise the lowest index wins.
module encoder32x5_rr #(
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2**IDX_W-1:0]   req,
  input  logic                  enable,
  output logic                  out_valid,
  output logic [IDX_W-1:0]      out_idx,
  input  logic                  out_ready,
  output logic [2**IDX_W-1:0]   out_onehot,
  output logic                  none_pending
);

  localparam int NREQ = 2**IDX_W;

  logic              accept;
  logic [NREQ-1:0]   accept_mask;
  logic [NREQ-1:0]   eff_req;
  logic              load;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cand;

  assign accept       = out_valid & out_ready;
  assign accept_mask  = accept ? out_onehot : '0;
  assign eff_req      = req & ~accept_mask;
  assign none_pending = ~|eff_req;
  assign load         = enable & (|eff_req) & (~out_valid | out_ready);

  // Walk candidates from farthest to nearest so the nearest set bit after ptr wins;
  // the IDX_W-bit add gives the modular wrap for free.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int unsigned j = NREQ; j > 0; j--) begin
      cand = ptr + IDX_W'(j - 1);
      if (eff_req[cand]) idx = cand;
    end
  end

`ifdef RR_FAIRNESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= idx + IDX_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_idx    <= idx;
      out_onehot <= {{(NREQ-1){1'b0}}, 1'b1} << idx;
    end else if (accept) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end
  end

endmodule

// File: tb/tb_encoder32x5_rr.sv
// Self-checking bench for encoder32x5_rr: directed scenarios plus random traffic
// compared against a behavioural grant model.
module tb_encoder32x5_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req;
  logic        enable;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        out_ready;
  logic [31:0] out_onehot;
  logic        none_pending;

  int checks   = 0;
  int failures = 0;

  bit m_valid;
  int m_idx;
  int m_ptr;

  encoder32x5_rr #(.IDX_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .enable       (enable),
    .out_valid    (out_valid),
    .out_idx      (out_idx),
    .out_ready    (out_ready),
    .out_onehot   (out_onehot),
    .none_pending (none_pending)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [31:0] eff, input int p);
    for (int k = 0; k < 32; k++) begin
      int i;
      i = (p + k) % 32;
      if (eff[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, "_idx"}, {27'd0, out_idx}, 32'(m_idx));
    chk({tag, "_onehot"}, out_onehot, m_valid ? (32'h1 << m_idx) : 32'h0);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  // One clock cycle: apply inputs, check the combinational flag, advance model, check registers.
  task automatic step(input logic [31:0] r, input logic en, input logic rdy, input string tag);
    logic [31:0] eff;
    int          g;
    bit          acc;
    req       = r;
    enable    = en;
    out_ready = rdy;
    #3;
    acc = m_valid && rdy;
    eff = r;
    if (acc) eff[m_idx] = 1'b0;
    chk({tag, "_none_pending"}, {31'd0, none_pending}, {31'd0, (eff == 32'h0)});
    g = search(eff, m_ptr);
    if (en && g >= 0 && (!m_valid || rdy)) begin
      m_valid = 1'b1;
      m_idx   = g;
`ifdef RR_FAIRNESS_EN
      m_ptr   = (g + 1) % 32;
`endif
    end else if (acc) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    enable    = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #8;
    chk_outputs("reset");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request: granted, then masked during its own accept.
    step(32'h0000_0001, 1'b1, 1'b1, "single_grant");
    chk("single_grant_idx0", {27'd0, out_idx}, 32'd0);
    step(32'h0000_0001, 1'b1, 1'b1, "single_masked");
    chk("single_masked_valid", {31'd0, out_valid}, 32'd0);

    // All requesters active for 33 cycles.
    for (int i = 0; i < 33; i++) step(32'hFFFF_FFFF, 1'b1, 1'b1, "full");

    // Stall holds the grant while req changes.
    step(32'h0000_0110, 1'b1, 1'b1, "stall_cap");
    chk("stall_cap_idx4", {27'd0, out_idx}, 32'd4);
    for (int i = 0; i < 5; i++) step(32'h8000_0000, 1'b1, 1'b0, "stall_hold");
    chk("stall_hold_idx4", {27'd0, out_idx}, 32'd4);
    step(32'h8000_0000, 1'b1, 1'b1, "stall_release");
    chk("stall_release_idx31", {27'd0, out_idx}, 32'd31);
    step(32'h0000_0000, 1'b1, 1'b1, "drain");

    // Wrap past the top of the index range.
    step(32'h2000_0000, 1'b1, 1'b1, "wrap_29");
    step(32'h0000_0003, 1'b1, 1'b1, "wrap_0");
    chk("wrap_idx0", {27'd0, out_idx}, 32'd0);
    step(32'h0000_0003, 1'b1, 1'b1, "wrap_1");
    chk("wrap_idx1", {27'd0, out_idx}, 32'd1);
    step(32'h0000_0000, 1'b1, 1'b1, "drain2");

    // Disabled arbitration drains the output without a new capture.
    step(32'h0000_0001, 1'b1, 1'b1, "dis_grant");
    step(32'h0000_0080, 1'b0, 1'b1, "dis_drain");
    chk("dis_drain_valid", {31'd0, out_valid}, 32'd0);
    step(32'h0000_0080, 1'b0, 1'b1, "dis_idle");

    // Asynchronous reset while a grant is stalled.
    step(32'h0000_0010, 1'b1, 1'b1, "rst_cap");
    step(32'h0000_0000, 1'b1, 1'b0, "rst_stall");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("async_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(32'h0000_0040, 1'b1, 1'b1, "post_reset");
    chk("post_reset_idx6", {27'd0, out_idx}, 32'd6);

    // Random traffic with sparse and dense request patterns.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      case ($urandom_range(0, 3))
        0:       r = 32'h1 << $urandom_range(0, 31);
        1:       r = $urandom() & $urandom() & $urandom();
        2:       r = $urandom();
        default: r = 32'h0;
      endcase
      step(r, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
